mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mdu.sv
// MDU: HI/LO multiply-divide unit with a 32-cycle restoring divider and MTHI/MTLO/MFHI/MFLO access.
// Define MDU_ITER_MULT_EN to run MULT/MULTU through the shared 32-cycle shift-add path.
module mdu (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        mult,
   input  logic        div,
   input  logic        mdsign,
   input  logic [1:0]  hilowen,
   input  logic [1:0]  hiloren,
   input  logic [31:0] rega,
   input  logic [31:0] regb,
   input  logic        ex_flush,
   output logic        stall,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rdata
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e      state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [31:0] opA_q, opA_d;
   logic [31:0] opB_q, opB_d;
   logic [31:0] acc_q, acc_d;
   logic        negLo_q, negLo_d;
   logic        negHi_q, negHi_d;
   logic        isMult_q, isMult_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic        iterOp;
   logic        fastMultWe;
   logic [63:0] fastProduct;
   logic        signA, signB;
   logic [31:0] magA, magB;
   logic        idleLive, accept;
   logic [32:0] trial, mulSum;
   logic        trialGeq;
   logic [63:0] product, productSigned;
   logic [31:0] quot, rem;

`ifdef MDU_ITER_MULT_EN
   assign iterOp      = div | mult;
   assign fastMultWe  = 1'b0;
   assign fastProduct = 64'd0;
`else
   logic [63:0] extA, extB;
   assign iterOp      = div;
   assign fastMultWe  = mult & ~div;
   assign extA        = {{32{mdsign & rega[31]}}, rega};
   assign extB        = {{32{mdsign & regb[31]}}, regb};
   assign fastProduct = extA * extB;
`endif

   assign busy  = (state_q != IDLE);
   assign stall = ~rst & in_valid & iterOp & (state_q != DONE) & ~ex_flush;
   assign hi    = hi_q;
   assign lo    = lo_q;
   assign rdata = hiloren[1] ? hi_q : (hiloren[0] ? lo_q : 32'd0);

   // Datapath works on magnitudes; signs are restored once, in DONE.
   always_comb begin
      signA         = mdsign & rega[31];
      signB         = mdsign & regb[31];
      magA          = signA ? (32'd0 - rega) : rega;
      magB          = signB ? (32'd0 - regb) : regb;
      idleLive      = (state_q == IDLE) & in_valid & ~ex_flush;
      accept        = idleLive & iterOp;
      trial         = {acc_q, opA_q[31]};
      trialGeq      = (trial >= {1'b0, opB_q});
      mulSum        = {1'b0, acc_q} + (opA_q[0] ? {1'b0, opB_q} : 33'd0);
      product       = {acc_q, opA_q};
      productSigned = negLo_q ? (64'd0 - product) : product;
      quot          = negLo_q ? (32'd0 - opA_q) : opA_q;
      rem           = negHi_q ? (32'd0 - acc_q) : acc_q;
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      opA_d    = opA_q;
      opB_d    = opB_q;
      acc_d    = acc_q;
      negLo_d  = negLo_q;
      negHi_d  = negHi_q;
      isMult_d = isMult_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = CALC;
               count_d  = 5'd0;
               opA_d    = magA;
               opB_d    = magB;
               acc_d    = 32'd0;
               negLo_d  = signA ^ signB;
               negHi_d  = signA;
               isMult_d = ~div;
            end else if (idleLive & fastMultWe) begin
               hi_d = fastProduct[63:32];
               lo_d = fastProduct[31:0];
            end else if (idleLive & ~mult & ~div) begin
               if (hilowen[0]) lo_d = rega;
               if (hilowen[1]) hi_d = rega;
            end
         end
         CALC: begin
            if (ex_flush) begin
               state_d = IDLE;
            end else begin
               count_d = count_q + 5'd1;
               if (isMult_q) begin
                  acc_d = mulSum[32:1];
                  opA_d = {mulSum[0], opA_q[31:1]};
               end else begin
                  acc_d = trialGeq ? (trial[31:0] - opB_q) : trial[31:0];
                  opA_d = {opA_q[30:0], trialGeq};
               end
               if (count_q == 5'd31) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (!ex_flush) begin
               if (isMult_q) begin
                  hi_d = productSigned[63:32];
                  lo_d = productSigned[31:0];
               end else begin
                  hi_d = rem;
                  lo_d = quot;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         count_q  <= 5'd0;
         opA_q    <= 32'd0;
         opB_q    <= 32'd0;
         acc_q    <= 32'd0;
         negLo_q  <= 1'b0;
         negHi_q  <= 1'b0;
         isMult_q <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         opA_q    <= opA_d;
         opB_q    <= opB_d;
         acc_q    <= acc_d;
         negLo_q  <= negLo_d;
         negHi_q  <= negHi_d;
         isMult_q <= isMult_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end
endmodule
